// File: rtl/reduce_cfg_pkg.sv
// Shared definitions for the reduce configuration sequencer.
// Provides the sequencer state type, the config ID width and the default
// config ID broadcast while no block is being addressed.
package reduce_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    GAP,
    SEND,
    FINAL
  } cfg_state_t;

  localparam int unsigned CFG_ID_W = 8;

  localparam logic [CFG_ID_W-1:0] DEFAULT_IDLE_CONFIG_ID = 8'hFF;

endpackage

// File: rtl/cfg_image_ram.sv
// Firmware image store: DEPTH x 8 RAM, one write port, one combinational
// read port. Contents are not reset.
// Ports:
//   clk   - clock
//   we    - write enable (caller guarantees waddr is in range)
//   waddr - write address
//   wdata - write byte
//   raddr - read address (out-of-range reads return 0)
//   rdata - read byte
module cfg_image_ram #(
  parameter int unsigned DEPTH = 12,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if ({1'b0, raddr} < DEPTH_W) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/reduce_config_sequencer.sv
// Reconfiguration sequencer for the trace pipeline's configurable blocks.
// Waits for the pipeline to drain, drops tracing, streams each block's
// firmware bytes on configId/configData (with an idle-ID gap before every
// block), then restores tracing and pulses done.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   start                 - one-cycle reconfiguration request (ignored while busy)
//   valid_in              - first pipeline stage valid, for drain detection
//   img_we/img_addr/img_data - host image write port (addr = block*MAX_CHAINS+chain)
//   tracing               - global tracing enable
//   configId/configData   - config broadcast bus
//   busy                  - sequence in progress
//   done                  - one-cycle pulse when tracing is restored
//   img_err               - sticky: image write attempted while busy
module reduce_config_sequencer
  import reduce_cfg_pkg::*;
#(
  parameter int unsigned         MAX_CHAINS     = 4,
  parameter int unsigned         NUM_BLOCKS     = 3,
  parameter logic [CFG_ID_W-1:0] IDLE_CONFIG_ID = DEFAULT_IDLE_CONFIG_ID,
  parameter int unsigned         DRAIN_CYCLES   = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     valid_in,
  input  logic                                     img_we,
  input  logic [$clog2(NUM_BLOCKS*MAX_CHAINS)-1:0] img_addr,
  input  logic [7:0]                               img_data,
  output logic                                     tracing,
  output logic [CFG_ID_W-1:0]                      configId,
  output logic [7:0]                               configData,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     img_err
);

  localparam int unsigned DEPTH = NUM_BLOCKS * MAX_CHAINS;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned QW    = $clog2(DRAIN_CYCLES + 2);
  localparam int unsigned BW    = $clog2(NUM_BLOCKS + 1);
  localparam int unsigned IW    = $clog2(MAX_CHAINS + 1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  cfg_state_t          state_q, state_d;
  logic [QW-1:0]       quiet_q, quiet_d;
  logic [BW-1:0]       blk_q, blk_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                tracing_q, tracing_d;
  logic [CFG_ID_W-1:0] cfg_id_q, cfg_id_d;
  logic [7:0]          cfg_data_q, cfg_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                img_err_q, img_err_d;

  logic                wr_en;
  logic [AW-1:0]       rd_addr;
  logic [7:0]          rd_data;
  logic [QW-1:0]       quiet_inc;

  assign wr_en     = img_we && !busy_q && ({1'b0, img_addr} < DEPTH_W);
  assign img_err_d = img_err_q | (img_we & busy_q);
  assign quiet_inc = quiet_q + QW'(1);

  // The read address follows the next-state block/index so the registered
  // configData lands in the same cycle as its configId.
  assign rd_addr = AW'(blk_d) * AW'(MAX_CHAINS) + AW'(idx_d);

  cfg_image_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (img_addr),
    .wdata (img_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    quiet_d   = quiet_q;
    blk_d     = blk_q;
    idx_d     = idx_q;
    tracing_d = tracing_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        tracing_d = 1'b1;
        if (start) begin
          busy_d = 1'b1;
          blk_d  = '0;
          idx_d  = '0;
          if (DRAIN_CYCLES == 0) begin
            state_d   = GAP;
            tracing_d = 1'b0;
          end else begin
            state_d = DRAIN;
            quiet_d = '0;
          end
        end
      end
      DRAIN: begin
        if (valid_in) begin
          quiet_d = '0;
        end else begin
          quiet_d = quiet_inc;
          if (quiet_inc == QW'(DRAIN_CYCLES)) begin
            state_d   = GAP;
            blk_d     = '0;
            tracing_d = 1'b0;
          end
        end
      end
      GAP: begin
        state_d = SEND;
        idx_d   = '0;
      end
      SEND: begin
        if (idx_q == IW'(MAX_CHAINS - 1)) begin
          if (blk_q < BW'(NUM_BLOCKS - 1)) begin
            blk_d   = blk_q + BW'(1);
            state_d = GAP;
          end else begin
            state_d = FINAL;
          end
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      FINAL: begin
        state_d   = IDLE;
        tracing_d = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b1;
      end
      default: begin
        state_d   = IDLE;
        tracing_d = 1'b1;
        busy_d    = 1'b0;
      end
    endcase

    cfg_id_d   = IDLE_CONFIG_ID;
    cfg_data_d = '0;
    if (state_d == SEND) begin
      cfg_id_d   = CFG_ID_W'(blk_d);
      cfg_data_d = rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      quiet_q    <= '0;
      blk_q      <= '0;
      idx_q      <= '0;
      tracing_q  <= 1'b1;
      cfg_id_q   <= IDLE_CONFIG_ID;
      cfg_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      img_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      quiet_q    <= quiet_d;
      blk_q      <= blk_d;
      idx_q      <= idx_d;
      tracing_q  <= tracing_d;
      cfg_id_q   <= cfg_id_d;
      cfg_data_q <= cfg_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      img_err_q  <= img_err_d;
    end
  end

  assign tracing    = tracing_q;
  assign configId   = cfg_id_q;
  assign configData = cfg_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign img_err    = img_err_q;

endmodule

// File: tb/tb_reduce_config_sequencer.sv
// Self-checking bench for reduce_config_sequencer: default configuration
// plus a small DRAIN_CYCLES=0 / MAX_CHAINS=2 / NUM_BLOCKS=1 instance.
module tb_reduce_config_sequencer;

  localparam int unsigned MC    = 4;
  localparam int unsigned NB    = 3;
  localparam int unsigned DC    = 4;
  localparam int unsigned DEPTH = MC * NB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, valid_in, img_we;
  logic [3:0] img_addr;
  logic [7:0] img_data;
  logic       tracing, busy, done, img_err;
  logic [7:0] configId, configData;

  logic       s_start, s_valid, s_we, s_addr;
  logic [7:0] s_data;
  logic       s_tracing, s_busy, s_done, s_err;
  logic [7:0] s_id, s_cdata;

  always #5 clk = ~clk;

  reduce_config_sequencer #(
    .MAX_CHAINS     (MC),
    .NUM_BLOCKS     (NB),
    .IDLE_CONFIG_ID (8'hFF),
    .DRAIN_CYCLES   (DC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .valid_in(valid_in),
    .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
    .tracing(tracing), .configId(configId), .configData(configData),
    .busy(busy), .done(done), .img_err(img_err)
  );

  reduce_config_sequencer #(
    .MAX_CHAINS     (2),
    .NUM_BLOCKS     (1),
    .IDLE_CONFIG_ID (8'hFF),
    .DRAIN_CYCLES   (0)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .valid_in(s_valid),
    .img_we(s_we), .img_addr(s_addr), .img_data(s_data),
    .tracing(s_tracing), .configId(s_id), .configData(s_cdata),
    .busy(s_busy), .done(s_done), .img_err(s_err)
  );

  int   checks = 0;
  int   errors = 0;
  logic [7:0] img [DEPTH];
  logic exp_err = 1'b0;
  bit   vq[$];

  typedef struct {
    bit         start;
    bit         valid;
    bit         e_tracing;
    bit         e_busy;
    logic [7:0] e_id;
    logic [7:0] e_data;
    bit         chk_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_img(input logic [3:0] a, input logic [7:0] d);
    img_we = 1'b1; img_addr = a; img_data = d;
    tick();
    img_we = 1'b0;
    if (a < DEPTH) img[a] = d;
  endtask

  // Model: after accept, tracing drops on the edge that completes DC
  // consecutive idle samples; then per block one idle-ID cycle followed by
  // MC bytes, one final idle-ID cycle, then tracing returns with done.
  task automatic run_seq(input bit inj_start, input bit inj_we, input bit we_on_accept);
    int         run;
    int         i;
    bit         dropped;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] eid[$];
    logic [7:0] edat[$];
    a = '0; d = '0;
    if (we_on_accept) begin
      a = 4'($urandom_range(0, DEPTH-1));
      d = 8'($urandom);
      img_we = 1'b1; img_addr = a; img_data = d;
    end
    start = 1'b1;
    tick();
    start = 1'b0; img_we = 1'b0;
    if (we_on_accept) img[a] = d;
    check("accept_busy", busy, 1);
    check("accept_tracing", tracing, 1);
    run = 0; dropped = 0; i = 0;
    while (!dropped && i < 64) begin
      valid_in = (i < vq.size()) ? vq[i] : 1'b0;
      tick();
      i++;
      run = valid_in ? 0 : run + 1;
      if (run == DC) dropped = 1;
      else check("drain_tracing", tracing, 1);
    end
    valid_in = 1'b0;
    check("drain_reached", dropped, 1);
    for (int b = 0; b < NB; b++) begin
      eid.push_back(8'hFF); edat.push_back(8'h00);
      for (int k = 0; k < MC; k++) begin
        eid.push_back(8'(b)); edat.push_back(img[b*MC+k]);
      end
    end
    eid.push_back(8'hFF); edat.push_back(8'h00);
    for (int j = 0; j < eid.size(); j++) begin
      check("seq_tracing", tracing, 0);
      check("seq_id", configId, eid[j]);
      if (j != eid.size() - 1) check("seq_data", configData, edat[j]);
      check("seq_busy", busy, 1);
      check("seq_done", done, 0);
      start = inj_start && (j == 2 || j == 7);
      if (inj_we && j == 3) begin
        img_we = 1'b1; img_addr = 4'd5; img_data = ~img[5];
        exp_err = 1'b1;
      end
      tick();
      start = 1'b0; img_we = 1'b0;
    end
    check("end_tracing", tracing, 1);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_img_err", img_err, exp_err);
    tick();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_id", configId, 8'hFF);
  endtask

  initial begin
    vec_t tbl[$];
    bit   seen;
    rst_n = 1'b0;
    start = 0; valid_in = 0; img_we = 0; img_addr = 0; img_data = 0;
    s_start = 0; s_valid = 0; s_we = 0; s_addr = 0; s_data = 0;
    #12;
    check("rst_tracing", tracing, 1);
    check("rst_id", configId, 8'hFF);
    check("rst_data", configData, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", img_err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Small instance: no drain wait; byte 1 written on the accept edge.
    s_we = 1; s_addr = 0; s_data = 8'hA0;
    tick();
    s_we = 1; s_addr = 1; s_data = 8'hA1; s_start = 1;
    tick();
    s_we = 0; s_start = 0;
    check("s_gap_tracing", s_tracing, 0);
    check("s_gap_id", s_id, 8'hFF);
    check("s_gap_busy", s_busy, 1);
    tick();
    check("s_b0_id", s_id, 8'h00);
    check("s_b0_data", s_cdata, 8'hA0);
    tick();
    check("s_b1_id", s_id, 8'h00);
    check("s_b1_data", s_cdata, 8'hA1);
    check("s_b1_tracing", s_tracing, 0);
    tick();
    check("s_fin_id", s_id, 8'hFF);
    check("s_fin_tracing", s_tracing, 0);
    tick();
    check("s_end_tracing", s_tracing, 1);
    check("s_end_done", s_done, 1);
    check("s_end_busy", s_busy, 0);
    tick();
    check("s_post_done", s_done, 0);

    // Main image 0x10..0x1B, plus ignored out-of-range writes.
    for (int i = 0; i < DEPTH; i++) write_img(4'(i), 8'(8'h10 + i));
    write_img(4'd12, 8'hEE);
    write_img(4'd15, 8'hEE);
    vq.delete();
    run_seq(0, 0, 0);

    // Drain interrupted by one busy sample.
    tbl.push_back('{1, 0, 1, 1, 8'hFF, 8'h00, 1});
    tbl.push_back('{0, 0, 1, 1, 8'hFF, 8'h00, 0});
    tbl.push_back('{0, 0, 1, 1, 8'hFF, 8'h00, 0});
    tbl.push_back('{0, 0, 1, 1, 8'hFF, 8'h00, 0});
    tbl.push_back('{0, 1, 1, 1, 8'hFF, 8'h00, 0});
    tbl.push_back('{0, 0, 1, 1, 8'hFF, 8'h00, 0});
    tbl.push_back('{0, 0, 1, 1, 8'hFF, 8'h00, 0});
    tbl.push_back('{0, 0, 1, 1, 8'hFF, 8'h00, 0});
    tbl.push_back('{0, 0, 0, 1, 8'hFF, 8'h00, 1});
    tbl.push_back('{0, 1, 0, 1, 8'h00, img[0], 1});
    tbl.push_back('{0, 0, 0, 1, 8'h00, img[1], 1});
    for (int r = 0; r < tbl.size(); r++) begin
      start = tbl[r].start; valid_in = tbl[r].valid;
      tick();
      start = 0;
      check($sformatf("tbl%0d_tracing", r), tracing, tbl[r].e_tracing);
      check($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
      check($sformatf("tbl%0d_id", r), configId, tbl[r].e_id);
      if (tbl[r].chk_data) check($sformatf("tbl%0d_data", r), configData, tbl[r].e_data);
    end
    valid_in = 0;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (done) seen = 1;
    end
    check("tbl_done_seen", seen, 1);
    tick();

    // Start pulses during an active sequence are ignored.
    run_seq(1, 0, 0);
    tick(); tick();
    check("no_restart_busy", busy, 0);
    check("no_restart_tracing", tracing, 1);

    // Write while busy is dropped and flags a sticky error.
    run_seq(0, 1, 0);
    tick(); tick();
    check("err_sticky", img_err, 1);
    run_seq(0, 0, 0);

    // Asynchronous reset in block 1, byte 2.
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < DC + 8; c++) tick();
    check("pre_rst_id", configId, 8'h01);
    check("pre_rst_data", configData, img[6]);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tracing", tracing, 1);
    check("mid_rst_id", configId, 8'hFF);
    check("mid_rst_data", configData, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", img_err, 0);
    tick();
    rst_n = 1'b1;
    exp_err = 1'b0;
    tick();
    run_seq(0, 0, 0);

    // Randomized image updates and drain traffic.
    for (int it = 0; it < 20; it++) begin
      for (int w = 0; w < 3; w++) write_img(4'($urandom_range(0, 15)), 8'($urandom));
      vq.delete();
      for (int k = 0, n = $urandom_range(0, 10); k < n; k++)
        vq.push_back($urandom_range(0, 2) == 0);
      run_seq(0, 0, bit'($urandom_range(0, 1)));
      for (int k = 0, n = $urandom_range(0, 3); k < n; k++) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reduce_config_sequencer.md
Name: reduce_config_sequencer

Overview:
- Sequences reconfiguration of the trace pipeline's configurable blocks, such as the vector scalar reduce units, over the shared configId/configData broadcast bus.
- Holds a host-loaded firmware image of NUM_BLOCKS x MAX_CHAINS bytes.
- On a start request it waits for the trace pipeline to drain, drops tracing, streams each block's bytes under that block's config ID, then restores tracing.
- Sits between the host/control interface and every block that owns a PERSONAL_CONFIG_ID.

Parameters:
- MAX_CHAINS, 4, firmware bytes per configurable block (one per chain).
- NUM_BLOCKS, 3, number of configurable blocks; block b uses config ID b, so NUM_BLOCKS must be <= 255.
- IDLE_CONFIG_ID, 8'hFF, config ID driven whenever no block is being addressed; must differ from 0..NUM_BLOCKS-1.
- DRAIN_CYCLES, 4, consecutive idle cycles of valid_in required before tracing is dropped; 0 means no wait.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle reconfiguration request.
- valid_in  in  1  valid of the first trace pipeline stage, used for drain detection.
- img_we  in  1  image write enable.
- img_addr  in  $clog2(NUM_BLOCKS*MAX_CHAINS)  image byte address; address = block*MAX_CHAINS + chain.
- img_data  in  8  image write byte.
- tracing  out  1  global tracing enable.
- configId  out  8  broadcast config ID.
- configData  out  8  broadcast config byte.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when tracing is restored.
- img_err  out  1  sticky flag: a write was attempted while busy.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: tracing=1, configId=IDLE_CONFIG_ID, configData=0, busy=0, done=0, img_err=0, state=IDLE.
- Image RAM is not reset. Its contents are undefined until written.
- States: IDLE, DRAIN, GAP, SEND, FINAL.
- IDLE
  - start=1 at edge e0 sets busy=1 from e0.
  - If DRAIN_CYCLES=0, go directly to GAP; otherwise go to DRAIN with quiet counter=0.
  - start while busy is ignored.
- DRAIN
  - tracing stays 1.
  - Each edge samples valid_in: 0 increments the quiet counter, 1 clears it.
  - On the edge where the count reaches DRAIN_CYCLES, go to GAP with block=0 and tracing<=0.
  - There is no timeout; continuous traffic holds DRAIN indefinitely.
- GAP (1 cycle)
  - tracing=0, configId=IDLE_CONFIG_ID, configData=0.
  - This guarantees every block's byte counter is cleared before it is addressed.
  - Next state: SEND with byte index=0.
- SEND (MAX_CHAINS cycles per block)
  - tracing=0, configId=block, configData=image[block*MAX_CHAINS+index].
  - Byte k of a block appears in the k-th SEND cycle.
  - After index MAX_CHAINS-1: if block<NUM_BLOCKS-1, increment block and go to GAP; otherwise go to FINAL.
- FINAL (1 cycle)
  - tracing=0, configId=IDLE_CONFIG_ID.
  - Next edge: tracing<=1, busy<=0, done<=1 for one cycle, state IDLE.
- Timing: tracing is low for exactly NUM_BLOCKS*(MAX_CHAINS+1)+1 cycles.
- Image writes
  - Accepted only while busy=0; the image is written on the edge.
  - img_addr >= NUM_BLOCKS*MAX_CHAINS is ignored with no error.
  - A write while busy is dropped and sets img_err; only reset clears img_err.
  - Image read is combinational or 1-cycle registered. If registered, the read is prefetched so configData still aligns with configId.
- Simultaneous start and img_we in IDLE: the write is committed and the sequence uses the new byte.
- Reset mid-operation: outputs return to reset values immediately, including tracing=1. The partial configuration is not resumed; the host must issue start again.
- configId/configData change only on clock edges and never glitch between blocks.

Decomposition:
- Shared package reduce_cfg_pkg contains:
  - the state enum cfg_state_t {IDLE, DRAIN, GAP, SEND, FINAL};
  - the constant CFG_ID_W=8;
  - the default IDLE_CONFIG_ID.
- One sub-module, cfg_image_ram: an NUM_BLOCKS*MAX_CHAINS x 8 single-write-port, single-read-port RAM.
- FSM and counters live in the top module.

Test Plan:
- Reset with rst_n=0 mid-SEND (block 1, byte 2): tracing=1, configId=8'hFF, busy=0 in the same cycle without waiting for clk. After release, the next start reruns the full sequence from block 0.
- Load image bytes 0x10..0x1B, hold valid_in=0, pulse start:
  - tracing falls 4 cycles after the accept edge;
  - configId sequence is FF,0,0,0,0,FF,1,1,1,1,FF,2,2,2,2,FF;
  - configData is 0x10..0x1B aligned with the IDs;
  - tracing stays low for 16 cycles;
  - done pulses once as tracing returns to 1.
- Drain interruption: valid_in=0 for 3 cycles, 1 for 1 cycle, then 0. tracing stays 1 until 4 consecutive idle samples, then the sequence starts.
- start pulses at cycles 2 and 7 of an active sequence: ignored, with exactly one done pulse and no restart.
- img_we during SEND at address 5: the byte is not written, img_err=1 and sticky, and the next sequence still sends the old value.
- DRAIN_CYCLES=0, MAX_CHAINS=2, NUM_BLOCKS=1: tracing falls 1 cycle after start. IDs are FF,0,0,FF, then tracing=1 with done after 4 low cycles.
